// File: rtl/down_counter_timer.sv
// Loadable down counter / timer with terminal-count pulse.
// Counts a loaded value toward zero on enabled clocks; one-shot mode stops
// in DONE with a sticky done flag, auto-reload mode restarts from the
// reload register to produce a periodic tick.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= ZERO;
      rld_q   <= ZERO;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; event priority is load > stop > start > count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;
    done_d  = done_q;

    if (load) begin
      cnt_d   = load_val;
      rld_d   = load_val;
      state_d = S_IDLE;
      done_d  = 1'b0;
    end else if (stop) begin
      // Stop pauses a running count and also masks a coincident start.
      if (state_q == S_RUN) begin
        state_d = S_IDLE;
      end
    end else if (start && (state_q != S_RUN)) begin
      // A zero count cannot be started: nothing to count down.
      if (cnt_q != ZERO) begin
        state_d = S_RUN;
        done_d  = 1'b0;
      end
    end else if ((state_q == S_RUN) && en) begin
      if (cnt_q > ONE) begin
        cnt_d = cnt_q - ONE;
      end else if (cnt_q == ONE) begin
        tc_d = 1'b1;
        if (auto_reload) begin
          // Reload instead of showing 0, so the period is rld enabled cycles.
          cnt_d = rld_q;
        end else begin
          cnt_d   = ZERO;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
    end
  end

  assign cnt  = cnt_q;
  assign busy = (state_q == S_RUN);
  assign tc   = tc_q;
  assign done = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: each step drives inputs, pushes the
// expected outputs onto a scoreboard queue, then pops and checks them after
// the clock edge.
module tb_down_counter_timer;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         stop;
  logic         en;
  logic         auto_reload;
  logic [W-1:0] cnt;
  logic         busy;
  logic         tc;
  logic         done;

  typedef struct {
    logic [W-1:0] cnt;
    logic         busy;
    logic         tc;
    logic         done;
  } exp_t;

  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .en          (en),
    .auto_reload (auto_reload),
    .cnt         (cnt),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Compare current DUT outputs against the oldest scoreboard entry.
  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s scoreboard empty observed=%0h expected=entry", tag, cnt);
    end else begin
      e = sb.pop_front();
      chk({tag, ".cnt"},  16'(cnt),  16'(e.cnt));
      chk({tag, ".busy"}, 16'(busy), 16'(e.busy));
      chk({tag, ".tc"},   16'(tc),   16'(e.tc));
      chk({tag, ".done"}, 16'(done), 16'(e.done));
      $display("step %-10s cnt=%0d busy=%0b tc=%0b done=%0b", tag, cnt, busy, tc, done);
    end
  endtask

  // One clock step: drive inputs, push expectation, sample 1 time unit after the edge.
  task automatic cyc(input string tag,
                     input logic ld, input logic [W-1:0] lv, input logic st,
                     input logic sp, input logic e, input logic ar,
                     input logic [W-1:0] ec, input logic eb, input logic et,
                     input logic ed);
    exp_t x;
    load = ld; load_val = lv; start = st; stop = sp; en = e; auto_reload = ar;
    x.cnt = ec; x.busy = eb; x.tc = et; x.done = ed;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic push_now(input logic [W-1:0] ec, input logic eb, input logic et, input logic ed);
    exp_t x;
    x.cnt = ec; x.busy = eb; x.tc = et; x.done = ed;
    sb.push_back(x);
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0;
    en = 1'b0; auto_reload = 1'b0;

    // 1. Asynchronous reset with no clock edge, then zero-count start guard.
    #1 rst = 1'b1;
    #1;
    push_now(4'd0, 1'b0, 1'b0, 1'b0);
    check_out("rst_async");
    #1 rst = 1'b0;
    cyc("start_zero", 0, 0, 1, 0, 0, 0, 4'd0, 0, 0, 0);

    // 2. One-shot count from 5.
    cyc("ld5",   1, 4'd5, 0, 0, 0, 0, 4'd5, 0, 0, 0);
    cyc("go5",   0, 0,    1, 0, 1, 0, 4'd5, 1, 0, 0);
    cyc("os4",   0, 0,    0, 0, 1, 0, 4'd4, 1, 0, 0);
    cyc("os3",   0, 0,    0, 0, 1, 0, 4'd3, 1, 0, 0);
    cyc("os2",   0, 0,    0, 0, 1, 0, 4'd2, 1, 0, 0);
    cyc("os1",   0, 0,    0, 0, 1, 0, 4'd1, 1, 0, 0);
    cyc("os0",   0, 0,    0, 0, 1, 0, 4'd0, 0, 1, 1);
    for (int i = 0; i < 10; i++)
      cyc("done_hold", 0, 0, 0, 0, 1, 0, 4'd0, 0, 0, 1);
    cyc("done_start", 0, 0, 1, 0, 1, 0, 4'd0, 0, 0, 1);

    // 3. Auto-reload period 3.
    cyc("ld3",   1, 4'd3, 0, 0, 0, 1, 4'd3, 0, 0, 0);
    cyc("go3",   0, 0,    1, 0, 1, 1, 4'd3, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc("ar2", 0, 0, 0, 0, 1, 1, 4'd2, 1, 0, 0);
      cyc("ar1", 0, 0, 0, 0, 1, 1, 4'd1, 1, 0, 0);
      cyc("ar3", 0, 0, 0, 0, 1, 1, 4'd3, 1, 1, 0);
    end
    cyc("ar_stop", 0, 0, 0, 1, 1, 1, 4'd3, 0, 0, 0);

    // 4. Max load value, en gating, stop and resume.
    cyc("ld15",  1, 4'd15, 0, 0, 0, 0, 4'd15, 0, 0, 0);
    cyc("go15",  0, 0,     1, 0, 0, 0, 4'd15, 1, 0, 0);
    cyc("en1a",  0, 0,     0, 0, 1, 0, 4'd14, 1, 0, 0);
    cyc("en0",   0, 0,     0, 0, 0, 0, 4'd14, 1, 0, 0);
    cyc("en1b",  0, 0,     0, 0, 1, 0, 4'd13, 1, 0, 0);
    cyc("en1c",  0, 0,     0, 0, 1, 0, 4'd12, 1, 0, 0);
    cyc("stop12",0, 0,     0, 1, 1, 0, 4'd12, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("hold12", 0, 0, 0, 0, 1, 0, 4'd12, 0, 0, 0);
    cyc("resume",0, 0,     1, 0, 1, 0, 4'd12, 1, 0, 0);
    cyc("dec11", 0, 0,     0, 0, 1, 0, 4'd11, 1, 0, 0);
    cyc("dec10", 0, 0,     0, 0, 1, 0, 4'd10, 1, 0, 0);

    // 5. Simultaneous events.
    cyc("ld7st", 1, 4'd7, 1, 0, 1, 0, 4'd7, 0, 0, 0);
    cyc("go7",   0, 0,    1, 0, 1, 0, 4'd7, 1, 0, 0);
    cyc("dec6",  0, 0,    0, 0, 1, 0, 4'd6, 1, 0, 0);
    cyc("spst",  0, 0,    1, 1, 1, 0, 4'd6, 0, 0, 0);
    cyc("go6",   0, 0,    1, 0, 1, 0, 4'd6, 1, 0, 0);
    for (int v = 5; v >= 1; v--)
      cyc("run6", 0, 0, 0, 0, 1, 0, 4'(v), 1, 0, 0);
    cyc("end6",  0, 0,    0, 0, 1, 0, 4'd0, 0, 1, 1);
    cyc("ld9dn", 1, 4'd9, 0, 0, 1, 0, 4'd9, 0, 0, 0);

    // Auto-reload with rld == 1: tc on every enabled cycle, cnt stays 1.
    cyc("ld1",   1, 4'd1, 0, 0, 0, 1, 4'd1, 0, 0, 0);
    cyc("go1",   0, 0,    1, 0, 1, 1, 4'd1, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("tick1", 0, 0, 0, 0, 1, 1, 4'd1, 1, 1, 0);
    cyc("tick1_en0", 0, 0, 0, 0, 0, 1, 4'd1, 1, 0, 0);

    // 6. Asynchronous reset mid-RUN.
    cyc("ld4",   1, 4'd4, 0, 0, 0, 0, 4'd4, 0, 0, 0);
    cyc("go4",   0, 0,    1, 0, 1, 0, 4'd4, 1, 0, 0);
    cyc("dec3",  0, 0,    0, 0, 1, 0, 4'd3, 1, 0, 0);
    cyc("dec2",  0, 0,    0, 0, 1, 0, 4'd2, 1, 0, 0);
    #1 rst = 1'b1;
    #1;
    push_now(4'd0, 1'b0, 1'b0, 1'b0);
    check_out("rst_mid");
    #1 rst = 1'b0;
    cyc("st_after", 0, 0, 1, 0, 1, 0, 4'd0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Loadable down counter and timer, the counting-down counterpart of the team's free-running up counter. A start value is loaded, the block counts toward zero one step per enabled clock, and it flags the terminal count. It supports one-shot and auto-reload (periodic tick) modes and is used as a timeout or tick generator beside the up counter.

Parameters:
WIDTH, 4, counter and load-value width in bits (legal range 2..16)

Ports:
clk  in  1  system clock, rising-edge active
rst  in  1  reset: asynchronous assert, active-high; returns all state to the reset values
load  in  1  capture load_val into cnt and the reload register rld
load_val  in  WIDTH  start/reload value
start  in  1  begin or resume counting
stop  in  1  pause counting; cnt holds its value
en  in  1  count enable (clock-enable / prescaler tick)
auto_reload  in  1  1 = periodic mode, 0 = one-shot mode
cnt  out  WIDTH  current count, registered
busy  out  1  high while in RUN
tc  out  1  terminal-count pulse, registered, exactly 1 cycle per terminal event
done  out  1  one-shot finished; sticky

Behaviour:
- Reset (rst=1, asynchronous): cnt=0, rld=0, state=IDLE, busy=0, tc=0, done=0. No output changes until the first clk edge after rst deasserts.
- States:
  - IDLE: loaded or paused, not counting.
  - RUN: counting.
  - DONE: one-shot expired.
- busy is decoded directly from the state register: busy=1 only in RUN.
- Priority per edge: rst > load > stop > start > count.
- load (any state):
  - cnt<=load_val, rld<=load_val, state<=IDLE, done<=0, tc<=0.
  - A start in the same cycle is ignored.
- stop in RUN: state<=IDLE; cnt unchanged; no tc. If stop and start are both high, stop wins.
- start in IDLE or DONE:
  - If cnt!=0: state<=RUN and done<=0.
  - If cnt==0: start is ignored and the state is unchanged (zero-count guard). done is not cleared.
  - start while already in RUN has no effect.
- Counting in RUN:
  - The first decrement happens at the edge after the one that entered RUN.
  - en=0: cnt holds and tc=0.
  - en=1 and cnt>1: cnt<=cnt-1.
  - en=1, cnt==1, auto_reload=0: cnt<=0, tc<=1, done<=1, state<=DONE.
  - en=1, cnt==1, auto_reload=1: cnt<=rld, tc<=1, state stays RUN. cnt never shows 0, so the period is rld enabled cycles.
- If auto_reload=1 with rld==1, tc is high on every enabled cycle and cnt stays 1.
- auto_reload is sampled only at the cnt==1 decision edge; changing it at other times has no effect.
- tc defaults to 0 on every edge where it is not set.
- Arithmetic:
  - Unsigned.
  - cnt never decrements below 0; no wrap to all-ones.
  - load_val = 2^WIDTH-1 is legal.
- DONE: cnt holds 0 and done=1 until load, or until start with cnt!=0 (unreachable from DONE without a load).
- Reset asserted mid-RUN forces reset values immediately, without waiting for a clock edge.

Test Plan:
1. Assert rst without clk edges, then release -> cnt=0, busy=0, tc=0, done=0; start with cnt=0 -> state stays IDLE, busy=0.
2. WIDTH=4: load 5, start, en=1, auto_reload=0 -> cnt 5,4,3,2,1,0 on successive edges; tc=1 only in the cycle cnt reads 0; done=1 and busy=0 from that cycle; cnt stays 0 for 10 more cycles.
3. Load 3, auto_reload=1, start, en=1 -> cnt 3,2,1,3,2,1,3...; tc high exactly once every 3 cycles, coincident with each reload to 3; busy held 1.
4. Load 15, start, en toggling 1,0,1,1 -> cnt 15,14,14,13,12. Then stop at cnt=12 -> busy=0, cnt holds 12 for 4 cycles. Then start -> cnt 11,10...
5. Simultaneous events: load(7)+start same cycle -> cnt=7, IDLE, busy=0; stop+start in RUN -> IDLE, cnt held; load(9) in DONE -> done=0, cnt=9, IDLE.
6. Load 4, start, assert rst asynchronously between edges at cnt=2 -> cnt=0, busy=0, tc=0, done=0 immediately; after release, start is ignored (cnt=0).
